// File: rtl/packet_capture.sv
// Receive-side packet reassembly: collects NBYTES UART bytes (first byte -> LSBs)
// into a holding register with a valid/ack handshake and an inter-byte timeout.
module packet_capture #(
  parameter int NBYTES      = 22,
  parameter int TIMEOUT_CYC = 50000,
  parameter int TW          = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  input  logic                rx_error,
  output logic [8*NBYTES-1:0] pkt_data,
  output logic                pkt_valid,
  input  logic                pkt_ack,
  output logic                overrun,
  output logic                timeout,
  output logic                frame_err,
  output logic [4:0]          byte_idx
);

  localparam int              PW       = 8 * NBYTES;
  localparam int              IW       = (PW > 8) ? $clog2(PW) : 3;
  localparam logic [4:0]      LAST_IDX = 5'(NBYTES - 1);
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [PW-1:0]   buffer;
  logic [PW-1:0]   next_buf;
  logic [IW-1:0]   slot;
  logic            accept;
  logic            last;

  // An error strobe always wins over a simultaneous byte.
  assign accept = rx_valid && !rx_error;
  // byte_idx is 0 in IDLE, so NBYTES=1 completes straight from IDLE.
  assign last   = accept && (byte_idx == LAST_IDX);
  assign slot   = IW'({byte_idx, 3'b000});

  always_comb begin
    next_buf             = buffer;
    next_buf[slot +: 8]  = rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      byte_idx  <= 5'd0;
      timer     <= '0;
      buffer    <= '0;
      pkt_data  <= '0;
      pkt_valid <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      timeout   <= 1'b0;
      frame_err <= 1'b0;

      if (pkt_valid && pkt_ack)
        pkt_valid <= 1'b0;

      // Completion overrides a same-cycle ack; without an ack it is an overrun.
      if (last) begin
        pkt_data  <= next_buf;
        pkt_valid <= 1'b1;
        overrun   <= pkt_valid && !pkt_ack;
      end

      if (accept)
        buffer <= next_buf;

      case (state)
        IDLE: begin
          timer <= '0;
          if (accept) begin
            if (last) begin
              byte_idx <= 5'd0;
            end else begin
              byte_idx <= 5'd1;
              state    <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (rx_error) begin
            byte_idx  <= 5'd0;
            timer     <= '0;
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (rx_valid) begin
            timer <= '0;
            if (last) begin
              byte_idx <= 5'd0;
              state    <= IDLE;
            end else begin
              byte_idx <= byte_idx + 5'd1;
            end
          end else if (timer == TO_LAST) begin
            timer    <= '0;
            byte_idx <= 5'd0;
            timeout  <= 1'b1;
            state    <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
